// File: rtl/sync_ram_clr_if.sv
// sync_ram_clr_if: request/response bundle for the clearable synchronous RAM.
interface sync_ram_clr_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
);
    logic [DATAWIDTH-1:0] data_i;
    logic [ADDRWIDTH-1:0] addr_i;
    logic                 WEn_i;
    logic                 REn_i;
    logic                 clr_i;
    logic [DATAWIDTH-1:0] data_o;
    logic                 valid_o;
    logic                 busy_o;
    modport master (output data_i, addr_i, WEn_i, REn_i, clr_i, input data_o, valid_o, busy_o);
    modport slave  (input data_i, addr_i, WEn_i, REn_i, clr_i, output data_o, valid_o, busy_o);
endinterface

// File: rtl/sync_ram_clr.sv
// sync_ram_clr: single-port RAM with registered one-cycle read and a sweep engine that zeroes the array.
module sync_ram_clr #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10,
    parameter bit RDW_MODE  = 1'b0
) (
    input logic          clk_i,
    input logic          rst_i,
    sync_ram_clr_if.slave bus
);
    typedef enum logic {CLEAR, READY} state_t;
    localparam logic [ADDRWIDTH-1:0] LAST = '1;
    state_t               state, state_n;
    logic [ADDRWIDTH-1:0] cnt, cnt_n, mem_addr;
    logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];
    logic [DATAWIDTH-1:0] mem_din, rd_data;
    logic                 clearing, accept, mem_we, rd_en;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // The sweep stops by comparing against the last address, so the counter never wraps.
    always_comb begin
        clearing = state == CLEAR;
        accept   = !clearing && !bus.clr_i;
        state_n  = clearing ? (cnt == LAST ? READY : CLEAR) : (bus.clr_i ? CLEAR : READY);
        cnt_n    = (clearing && cnt != LAST) ? cnt + 1'b1 : '0;
        mem_we   = !rst_i && (clearing || (accept && bus.WEn_i));
        rd_en    = accept && bus.REn_i;
        mem_addr = clearing ? cnt : bus.addr_i;
        mem_din  = clearing ? '0 : bus.data_i;
        rd_data  = (RDW_MODE && bus.WEn_i) ? bus.data_i : mem[bus.addr_i];
    end
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.data_o  <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.valid_o <= rd_en;
            if (rd_en) bus.data_o <= rd_data;
        end
    end
    assign bus.busy_o = clearing;
endmodule

// File: tb/tb_sync_ram_clr.sv
// tb_sync_ram_clr: scoreboard bench for read-first, write-first and default-size RAM instances.
module tb_sync_ram_clr;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic rdy = 1'b0;
    logic [7:0] ma [16];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    logic [7:0] ea, eb;
    always #5 clk = ~clk;
    sync_ram_clr_if #(.DATAWIDTH(8), .ADDRWIDTH(4))  ia ();
    sync_ram_clr_if #(.DATAWIDTH(8), .ADDRWIDTH(4))  ib ();
    sync_ram_clr_if #(.DATAWIDTH(8), .ADDRWIDTH(10)) ic ();
    sync_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(4),  .RDW_MODE(1'b0)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia));
    sync_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(4),  .RDW_MODE(1'b1)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib));
    sync_ram_clr #(.DATAWIDTH(8), .ADDRWIDTH(10), .RDW_MODE(1'b0)) dut_c (.clk_i(clk), .rst_i(rst), .bus(ic));
    // Scoreboard: every valid pulse must match the oldest queued read, and a queued read must not go missing.
    always @(negedge clk) begin
        if (ia.valid_o === 1'b1) begin
            tests++;
            if (qa.size() == 0) begin
                fails++;
                $display("FAIL rd_a unexpected valid, data_o=%h", ia.data_o);
            end else begin
                ea = qa.pop_front();
                if (ia.data_o !== ea) begin
                    fails++;
                    $display("FAIL rd_a data_o=%h expected %h", ia.data_o, ea);
                end
            end
        end else if (qa.size() != 0) begin
            tests++;
            fails++;
            ea = qa.pop_front();
            $display("FAIL rd_a missing valid, valid_o=%b expected 1 (data %h)", ia.valid_o, ea);
        end
        if (ib.valid_o === 1'b1) begin
            tests++;
            if (qb.size() == 0) begin
                fails++;
                $display("FAIL rd_b unexpected valid, data_o=%h", ib.data_o);
            end else begin
                eb = qb.pop_front();
                if (ib.data_o !== eb) begin
                    fails++;
                    $display("FAIL rd_b data_o=%h expected %h", ib.data_o, eb);
                end
            end
        end else if (qb.size() != 0) begin
            tests++;
            fails++;
            eb = qb.pop_front();
            $display("FAIL rd_b missing valid, valid_o=%b expected 1 (data %h)", ib.valid_o, eb);
        end
    end
    task automatic step();
        @(negedge clk);
        #1;
    endtask
    task automatic drive(input logic we, input logic re, input logic clr, input logic [3:0] ad, input logic [7:0] d);
        ia.WEn_i = we; ia.REn_i = re; ia.clr_i = clr; ia.addr_i = ad; ia.data_i = d;
        ib.WEn_i = we; ib.REn_i = re; ib.clr_i = clr; ib.addr_i = ad; ib.data_i = d;
        if (rdy && clr) begin
            rdy = 1'b0;
            foreach (ma[i]) ma[i] = 8'h00;
        end else if (rdy) begin
            if (re) begin
                qa.push_back(ma[ad]);
                qb.push_back(we ? d : ma[ad]);
            end
            if (we) ma[ad] = d;
        end
        step();
    endtask
    task automatic count_busy16(input string tag);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
            tests++;
            if (ia.busy_o !== (i < 16) || ib.busy_o !== (i < 16)) begin
                fails++;
                $display("FAIL %s busy edge %0d: a=%b b=%b expected %b", tag, i, ia.busy_o, ib.busy_o, (i < 16));
            end
        end
        rdy = 1'b1;
    endtask
    task automatic read_all();
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        tests++;
        if (ia.busy_o !== 1'b1 || ia.valid_o !== 1'b0 || ia.data_o !== 8'h00) begin
            fails++;
            $display("FAIL reset_state busy=%b valid=%b data=%h expected 1 0 00", ia.busy_o, ia.valid_o, ia.data_o);
        end
        rst = 1'b0;
        foreach (ma[i]) ma[i] = 8'h00;
        count_busy16("reset");
        read_all();
    endtask
    task automatic test_write_read();
        drive(1'b1, 1'b0, 1'b0, 4'd3, 8'hA5);
        drive(1'b1, 1'b0, 1'b0, 4'd12, 8'h5A);
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 4'd12, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 4'd4, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask
    task automatic test_rdw();
        drive(1'b1, 1'b0, 1'b0, 4'd7, 8'h11);
        drive(1'b1, 1'b1, 1'b0, 4'd7, 8'h22);
        drive(1'b0, 1'b1, 1'b0, 4'd7, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask
    task automatic test_clear();
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, 4'(i), 8'hFF);
        drive(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 4'h0, 8'h33);
        tests++;
        if (ia.busy_o !== 1'b1 || ia.valid_o !== 1'b0) begin
            fails++;
            $display("FAIL clr_start busy=%b valid=%b expected 1 0", ia.busy_o, ia.valid_o);
        end
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, i == 8, 4'(i), 8'h77);
            tests++;
            if (ia.busy_o !== (i < 16) || ia.valid_o !== 1'b0 || ib.valid_o !== 1'b0) begin
                fails++;
                $display("FAIL clr_busy edge %0d: busy=%b valid=%b/%b expected %b 0", i, ia.busy_o, ia.valid_o, ib.valid_o, (i < 16));
            end
        end
        rdy = 1'b1;
        read_all();
    endtask
    task automatic test_rst_mid();
        drive(1'b1, 1'b0, 1'b0, 4'd1, 8'h5C);
        drive(1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 8'h00);
        tests++;
        if (ia.busy_o !== 1'b1 || ia.data_o !== 8'h5C) begin
            fails++;
            $display("FAIL clr_hold busy=%b data=%h expected 1 5c", ia.busy_o, ia.data_o);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        rst = 1'b1;
        #1;
        tests++;
        if (ia.busy_o !== 1'b1 || ia.valid_o !== 1'b0 || ia.data_o !== 8'h00 || ib.data_o !== 8'h00) begin
            fails++;
            $display("FAIL async_rst busy=%b valid=%b data=%h/%h expected 1 0 00", ia.busy_o, ia.valid_o, ia.data_o, ib.data_o);
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        rst = 1'b0;
        count_busy16("rst_mid");
        read_all();
    endtask
    task automatic test_default();
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            step();
            tests++;
            if (ic.busy_o !== (i < 1024)) begin
                fails++;
                $display("FAIL def_busy edge %0d: busy=%b expected %b", i, ic.busy_o, (i < 1024));
            end
        end
        ic.WEn_i = 1'b1; ic.addr_i = 10'h3FF; ic.data_i = 8'hC3;
        step();
        ic.WEn_i = 1'b0; ic.REn_i = 1'b1;
        step();
        tests++;
        if (ic.valid_o !== 1'b1 || ic.data_o !== 8'hC3) begin
            fails++;
            $display("FAIL def_top valid=%b data=%h expected 1 c3", ic.valid_o, ic.data_o);
        end
        ic.addr_i = 10'h000;
        step();
        tests++;
        if (ic.valid_o !== 1'b1 || ic.data_o !== 8'h00) begin
            fails++;
            $display("FAIL def_zero valid=%b data=%h expected 1 00", ic.valid_o, ic.data_o);
        end
        ic.REn_i = 1'b0;
        step();
        tests++;
        if (ic.valid_o !== 1'b0 || ic.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL def_idle valid=%b busy=%b expected 0 0", ic.valid_o, ic.busy_o);
        end
    endtask
    initial begin
        ic.WEn_i = 1'b0; ic.REn_i = 1'b0; ic.clr_i = 1'b0; ic.addr_i = '0; ic.data_i = '0;
        test_reset();
        test_write_read();
        test_rdw();
        test_clear();
        test_rst_mid();
        test_default();
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL leftover reads a=%0d b=%0d expected 0 0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
